// File: rtl/mem_access_unit.sv
// Memory stage: drives a req/gnt/rvalid data bus from the ALU address, aligns store lanes,
// extends load data, stalls the core while an access is in flight and pulses done on completion.
module mem_access_unit #(
    parameter int WORD    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic [WORD-1:0] mem_addr_i,
    input  logic [WORD-1:0] mem_wdata_i,
    input  logic            mem_read_i,
    input  logic            mem_write_i,
    input  logic [2:0]      mem_funct3_i,
    output logic            mem_stall_o,
    output logic [WORD-1:0] mem_rdata_o,
    output logic            mem_done_o,
    output logic            mem_misalign_o,
    output logic            mem_timeout_o,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [WORD-1:0] dmem_addr_o,
    output logic [3:0]      dmem_be_o,
    output logic [WORD-1:0] dmem_wdata_o,
    input  logic            dmem_gnt_i,
    input  logic            dmem_rvalid_i,
    input  logic [WORD-1:0] dmem_rdata_i
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    logic [1:0]      state;
    logic [7:0]      cnt;
    logic [WORD-1:0] addr_q;
    logic [WORD-1:0] wdata_q;
    logic [WORD-1:0] rdata_q;
    logic [3:0]      be_q;
    logic [2:0]      funct3_q;
    logic            we_q;
    logic            misalign_q;
    logic            timeout_q;
    logic            timeout_hit;
    logic            in_req;

    // Access size: funct3[1:0] 00 = byte, 01 = half, anything else = word.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = a[0];
            default: is_misaligned = (a != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   store_be = 4'b0001 << a;
            2'b01:   store_be = a[1] ? 4'b1100 : 4'b0011;
            default: store_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   store_data = {4{d[7:0]}};
            2'b01:   store_data = {2{d[15:0]}};
            default: store_data = d;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] d);
        logic [31:0] lane;
        lane = d >> {a, 3'b000};
        case (f3)
            3'b000:  load_extend = {{24{lane[7]}}, lane[7:0]};
            3'b100:  load_extend = {24'h0, lane[7:0]};
            3'b001:  load_extend = {{16{lane[15]}}, lane[15:0]};
            3'b101:  load_extend = {16'h0, lane[15:0]};
            default: load_extend = d;
        endcase
    endfunction

    assign timeout_hit = (cnt == TIMEOUT_CNT);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state      <= IDLE;
            cnt        <= 8'h0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            be_q       <= 4'h0;
            funct3_q   <= 3'h0;
            we_q       <= 1'b0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_read_i || mem_write_i) begin
                        addr_q    <= mem_addr_i;
                        wdata_q   <= store_data(mem_funct3_i, mem_wdata_i);
                        be_q      <= store_be(mem_funct3_i, mem_addr_i[1:0]);
                        funct3_q  <= mem_funct3_i;
                        we_q      <= mem_write_i;
                        rdata_q   <= '0;
                        timeout_q <= 1'b0;
                        cnt       <= 8'h0;
                        if (is_misaligned(mem_funct3_i, mem_addr_i[1:0])) begin
                            misalign_q <= 1'b1;
                            state      <= DONE;
                        end else begin
                            misalign_q <= 1'b0;
                            state      <= REQ;
                        end
                    end
                end
                REQ: begin
                    cnt <= cnt + 8'h1;
                    if (timeout_hit) begin
                        timeout_q <= 1'b1;
                        state     <= DONE;
                    end else if (dmem_gnt_i) begin
                        state <= we_q ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 8'h1;
                    if (timeout_hit) begin
                        timeout_q <= 1'b1;
                        state     <= DONE;
                    end else if (dmem_rvalid_i) begin
                        rdata_q <= load_extend(funct3_q, addr_q[1:0], dmem_rdata_i);
                        state   <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bus outputs are only driven while a request is being presented.
    assign in_req         = (state == REQ);
    assign dmem_req_o     = in_req && !timeout_hit;
    assign dmem_we_o      = in_req && we_q;
    assign dmem_addr_o    = in_req ? {addr_q[WORD-1:2], 2'b00} : '0;
    assign dmem_be_o      = in_req ? be_q : 4'h0;
    assign dmem_wdata_o   = in_req ? wdata_q : '0;

    assign mem_done_o     = (state == DONE);
    assign mem_stall_o    = rstn_i && (mem_read_i || mem_write_i) && (state != DONE);
    assign mem_rdata_o    = mem_done_o ? rdata_q : '0;
    assign mem_misalign_o = mem_done_o && misalign_q;
    assign mem_timeout_o  = mem_done_o && timeout_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: stores, loads with extension, misalignment, timeout
// and reset in the middle of a read.
module tb_mem_access_unit;

    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  mem_funct3 = 3'b010;
    logic        mem_stall;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        mem_misalign;
    logic        mem_timeout;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;

    int n_vec = 0;
    int n_err = 0;

    mem_access_unit #(.WORD(32), .TIMEOUT(TIMEOUT)) dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .mem_addr_i     (mem_addr),
        .mem_wdata_i    (mem_wdata),
        .mem_read_i     (mem_read),
        .mem_write_i    (mem_write),
        .mem_funct3_i   (mem_funct3),
        .mem_stall_o    (mem_stall),
        .mem_rdata_o    (mem_rdata),
        .mem_done_o     (mem_done),
        .mem_misalign_o (mem_misalign),
        .mem_timeout_o  (mem_timeout),
        .dmem_req_o     (dmem_req),
        .dmem_we_o      (dmem_we),
        .dmem_addr_o    (dmem_addr),
        .dmem_be_o      (dmem_be),
        .dmem_wdata_o   (dmem_wdata),
        .dmem_gnt_i     (dmem_gnt),
        .dmem_rvalid_i  (dmem_rvalid),
        .dmem_rdata_i   (dmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req"},   {31'h0, dmem_req},   32'h0);
        chk({tag, "_we"},    {31'h0, dmem_we},    32'h0);
        chk({tag, "_addr"},  dmem_addr,           32'h0);
        chk({tag, "_be"},    {28'h0, dmem_be},    32'h0);
        chk({tag, "_wdata"}, dmem_wdata,          32'h0);
        chk({tag, "_done"},  {31'h0, mem_done},   32'h0);
        chk({tag, "_stall"}, {31'h0, mem_stall},  32'h0);
        chk({tag, "_rdata"}, mem_rdata,           32'h0);
        chk({tag, "_flags"}, {30'h0, mem_misalign, mem_timeout}, 32'h0);
    endtask

    // Store with grant in the first REQ cycle; done lands two cycles after the request.
    task automatic run_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] exp_be,
                             input logic [31:0] exp_wdata);
        mem_funct3 = f3; mem_addr = a; mem_wdata = d; mem_write = 1'b1;
        tick;
        chk({tag, "_req"},   {31'h0, dmem_req},  32'h1);
        chk({tag, "_we"},    {31'h0, dmem_we},   32'h1);
        chk({tag, "_addr"},  dmem_addr,          {a[31:2], 2'b00});
        chk({tag, "_be"},    {28'h0, dmem_be},   {28'h0, exp_be});
        chk({tag, "_wdata"}, dmem_wdata,         exp_wdata);
        chk({tag, "_stall"}, {31'h0, mem_stall}, 32'h1);
        dmem_gnt = 1'b1;
        tick;
        dmem_gnt = 1'b0;
        chk({tag, "_done"},  {31'h0, mem_done},  32'h1);
        chk({tag, "_stall_done"}, {31'h0, mem_stall}, 32'h0);
        mem_write = 1'b0;
        tick;
        chk({tag, "_done_drop"}, {31'h0, mem_done}, 32'h0);
    endtask

    task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] rd, input logic [31:0] exp);
        mem_funct3 = f3; mem_addr = a; mem_read = 1'b1;
        tick;
        chk({tag, "_req"},  {31'h0, dmem_req}, 32'h1);
        chk({tag, "_we"},   {31'h0, dmem_we},  32'h0);
        chk({tag, "_addr"}, dmem_addr,         {a[31:2], 2'b00});
        dmem_gnt = 1'b1;
        tick;
        dmem_gnt = 1'b0;
        chk({tag, "_wait_req"},  {31'h0, dmem_req},  32'h0);
        chk({tag, "_wait_done"}, {31'h0, mem_done},  32'h0);
        chk({tag, "_wait_stall"}, {31'h0, mem_stall}, 32'h1);
        dmem_rvalid = 1'b1; dmem_rdata = rd;
        tick;
        dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        chk({tag, "_done"},  {31'h0, mem_done}, 32'h1);
        chk({tag, "_rdata"}, mem_rdata,         exp);
        chk({tag, "_flags"}, {30'h0, mem_misalign, mem_timeout}, 32'h0);
        mem_read = 1'b0;
        tick;
        chk({tag, "_done_drop"}, {31'h0, mem_done}, 32'h0);
    endtask

    task automatic run_misalign(input string tag, input logic [2:0] f3, input logic [31:0] a);
        mem_funct3 = f3; mem_addr = a; mem_read = 1'b1;
        #1;
        chk({tag, "_req_idle"}, {31'h0, dmem_req}, 32'h0);
        tick;
        chk({tag, "_req"},      {31'h0, dmem_req},     32'h0);
        chk({tag, "_done"},     {31'h0, mem_done},     32'h1);
        chk({tag, "_misalign"}, {31'h0, mem_misalign}, 32'h1);
        chk({tag, "_timeout"},  {31'h0, mem_timeout},  32'h0);
        chk({tag, "_rdata"},    mem_rdata,             32'h0);
        mem_read = 1'b0;
        tick;
        chk({tag, "_done_drop"}, {31'h0, mem_done}, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick;
        tick;
        check_all_zero("reset");
        #2 rstn = 1'b1;
        tick;

        run_store("sw",    3'b010, 32'h0000_1000, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
        run_store("sh_hi", 3'b001, 32'h0000_1002, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD);
        run_store("sh_lo", 3'b001, 32'h0000_1000, 32'h1234_ABCD, 4'b0011, 32'hABCD_ABCD);
        run_store("sb1",   3'b000, 32'h0000_1001, 32'h0000_00EF, 4'b0010, 32'hEFEF_EFEF);

        run_load("lb",    3'b000, 32'h0000_1003, 32'h8012_3456, 32'hFFFF_FF80);
        run_load("lbu",   3'b100, 32'h0000_1003, 32'h8012_3456, 32'h0000_0080);
        run_load("lhu",   3'b101, 32'h0000_1002, 32'h8765_4321, 32'h0000_8765);
        run_load("lh",    3'b001, 32'h0000_1000, 32'h0000_8001, 32'hFFFF_8001);
        run_load("lb0",   3'b000, 32'h0000_1000, 32'h8012_3456, 32'h0000_0056);
        run_load("lw",    3'b010, 32'h0000_1004, 32'h1357_9BDF, 32'h1357_9BDF);
        run_load("lw_f3", 3'b011, 32'h0000_1008, 32'hA5A5_5A5A, 32'hA5A5_5A5A);

        run_misalign("lw_mis", 3'b010, 32'h0000_1001);
        run_misalign("lh_mis", 3'b001, 32'h0000_1003);

        // Load that is never granted: request drops once the counter reaches TIMEOUT.
        mem_funct3 = 3'b010; mem_addr = 32'h0000_2000; mem_read = 1'b1;
        tick;
        repeat (TIMEOUT - 1) tick;
        chk("to_req_before", {31'h0, dmem_req}, 32'h1);
        chk("to_done_before", {31'h0, mem_done}, 32'h0);
        tick;
        chk("to_req_drop", {31'h0, dmem_req}, 32'h0);
        chk("to_done_early", {31'h0, mem_done}, 32'h0);
        tick;
        chk("to_done",    {31'h0, mem_done},     32'h1);
        chk("to_flag",    {31'h0, mem_timeout},  32'h1);
        chk("to_misal",   {31'h0, mem_misalign}, 32'h0);
        chk("to_rdata",   mem_rdata,             32'h0);
        mem_read = 1'b0;
        tick;
        chk("to_idle_done",  {31'h0, mem_done},  32'h0);
        chk("to_idle_stall", {31'h0, mem_stall}, 32'h0);
        chk("to_idle_req",   {31'h0, dmem_req},  32'h0);

        // Reset asserted while waiting for read data.
        mem_funct3 = 3'b010; mem_addr = 32'h0000_3000; mem_read = 1'b1;
        tick;
        dmem_gnt = 1'b1;
        tick;
        dmem_gnt = 1'b0;
        chk("rst_in_wait", {31'h0, mem_stall}, 32'h1);
        #2 rstn = 1'b0; mem_read = 1'b0;
        #1;
        check_all_zero("rst_async");
        tick;
        #2 rstn = 1'b1;
        tick;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_2222;
        tick;
        dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        chk("rst_stale_done", {31'h0, mem_done}, 32'h0);
        chk("rst_stale_req",  {31'h0, dmem_req}, 32'h0);
        run_load("post_rst_lw", 3'b010, 32'h0000_3000, 32'hCAFE_F00D, 32'hCAFE_F00D);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
